sigma_dmem_arb: RTL and testbench

Two-master round-robin arbiter that shares the single data-memory port of the sigma SoC between the CPU data bus (master 0) and the Sobel accelerator DMA (master 1). It forwards one request per cycle to the memory, locks the grant until the memory accepts, and returns in-order read responses to the requester that issued them through an ownership FIFO. It sits between the CPU/DMA bus ports and the on-chip RAM inside sigma.

---
 rtl/sigma_dmem_arb_if.sv | 44 ++++
 rtl/sigma_dmem_arb.sv | 124 ++++++++++++
 tb/tb_sigma_dmem_arb.sv | 489 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sigma_dmem_arb_if.sv
// Shared data-memory bus between the CPU/DMA masters, the arbiter and the RAM.
// The arbiter connects through the slave modport; the requesters and the memory use the master modport.
interface sigma_dmem_arb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    localparam int BE_W = DATA_W / 8;

    logic              m0_req_i,   m1_req_i;
    logic              m0_we_i,    m1_we_i;
    logic [ADDR_W-1:0] m0_addr_i,  m1_addr_i;
    logic [BE_W-1:0]   m0_be_i,    m1_be_i;
    logic [DATA_W-1:0] m0_wdata_i, m1_wdata_i;
    logic              m0_ack_o,   m1_ack_o;
    logic              m0_resp_o,  m1_resp_o;
    logic [DATA_W-1:0] m0_rdata_o, m1_rdata_o;

    logic              s_req_o;
    logic              s_we_o;
    logic [ADDR_W-1:0] s_addr_o;
    logic [BE_W-1:0]   s_be_o;
    logic [DATA_W-1:0] s_wdata_o;
    logic              s_ack_i;
    logic              s_resp_i;
    logic [DATA_W-1:0] s_rdata_i;

    modport master (
        output m0_req_i, m0_we_i, m0_addr_i, m0_be_i, m0_wdata_i,
        output m1_req_i, m1_we_i, m1_addr_i, m1_be_i, m1_wdata_i,
        input  m0_ack_o, m0_resp_o, m0_rdata_o,
        input  m1_ack_o, m1_resp_o, m1_rdata_o,
        input  s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o,
        output s_ack_i, s_resp_i, s_rdata_i
    );

    modport slave (
        input  m0_req_i, m0_we_i, m0_addr_i, m0_be_i, m0_wdata_i,
        input  m1_req_i, m1_we_i, m1_addr_i, m1_be_i, m1_wdata_i,
        output m0_ack_o, m0_resp_o, m0_rdata_o,
        output m1_ack_o, m1_resp_o, m1_rdata_o,
        output s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o,
        input  s_ack_i, s_resp_i, s_rdata_i
    );
endinterface

// File: rtl/sigma_dmem_arb.sv
// Round-robin arbiter sharing the sigma data-memory port between CPU (m0) and Sobel DMA (m1).
// Grant locks until the memory accepts; read responses are routed back through an ownership FIFO.
module sigma_dmem_arb #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MAX_OUTST = 4
) (
    input logic             clk_i,
    input logic             arst_n_i,
    sigma_dmem_arb_if.slave bus
);
    localparam int PTR_W = $clog2(MAX_OUTST);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        ST_FREE,
        ST_LOCKED
    } state_t;

    state_t           state_q, state_d;
    logic             owner_q, owner_d;
    logic             rr_q;
    logic             fifo_q [MAX_OUTST];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic fifo_full, fifo_empty;
    logic elig0, elig1;
    logic gnt_valid, gnt_id, gnt_we;
    logic accept, push, pop, head;

    assign fifo_full  = (count_q == CNT_W'(MAX_OUTST));
    assign fifo_empty = (count_q == '0);
    assign elig0      = bus.m0_req_i & (bus.m0_we_i | ~fifo_full);
    assign elig1      = bus.m1_req_i & (bus.m1_we_i | ~fifo_full);

    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        gnt_valid = 1'b0;
        gnt_id    = 1'b0;
        case (state_q)
            ST_LOCKED: begin
                gnt_id    = owner_q;
                gnt_valid = owner_q ? bus.m1_req_i : bus.m0_req_i;
            end
            default: begin
                if (elig0 && elig1) begin
                    gnt_valid = 1'b1;
                    gnt_id    = rr_q;
                end else if (elig0 || elig1) begin
                    gnt_valid = 1'b1;
                    gnt_id    = ~elig0;
                end
            end
        endcase
        // Outputs are combinational from the masters, so reset must mask the grant itself.
        if (!arst_n_i) gnt_valid = 1'b0;
        if (gnt_valid && !bus.s_ack_i) begin
            state_d = ST_LOCKED;
            owner_d = gnt_id;
        end else begin
            state_d = ST_FREE;
        end
    end

    always_comb begin
        bus.s_req_o   = gnt_valid;
        bus.s_we_o    = 1'b0;
        bus.s_addr_o  = '0;
        bus.s_be_o    = '0;
        bus.s_wdata_o = '0;
        gnt_we        = 1'b0;
        if (gnt_valid) begin
            gnt_we        = gnt_id ? bus.m1_we_i    : bus.m0_we_i;
            bus.s_we_o    = gnt_we;
            bus.s_addr_o  = gnt_id ? bus.m1_addr_i  : bus.m0_addr_i;
            bus.s_be_o    = gnt_id ? bus.m1_be_i    : bus.m0_be_i;
            bus.s_wdata_o = gnt_id ? bus.m1_wdata_i : bus.m0_wdata_i;
        end
    end

    assign accept = gnt_valid & bus.s_ack_i;
    assign push   = accept & ~gnt_we;
    // A response with nothing outstanding (e.g. in flight across a reset) is dropped.
    assign pop    = bus.s_resp_i & ~fifo_empty & arst_n_i;
    assign head   = fifo_q[rd_ptr_q];

    assign bus.m0_ack_o   = accept & ~gnt_id;
    assign bus.m1_ack_o   = accept & gnt_id;
    assign bus.m0_resp_o  = pop & ~head;
    assign bus.m1_resp_o  = pop & head;
    assign bus.m0_rdata_o = bus.m0_resp_o ? bus.s_rdata_i : '0;
    assign bus.m1_rdata_o = bus.m1_resp_o ? bus.s_rdata_i : '0;

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q  <= ST_FREE;
            owner_q  <= 1'b0;
            rr_q     <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            if (accept) rr_q <= ~gnt_id;
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            if (push && !pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // NOTE: FIFO storage is left unreset; count_q gates every read, so stale entries are never seen.
    always_ff @(posedge clk_i) begin
        if (push) fifo_q[wr_ptr_q] <= gnt_id;
    end
endmodule

// File: tb/tb_sigma_dmem_arb.sv
// Self-checking bench for sigma_dmem_arb: scoreboard of expected read owners/data,
// one task per scenario, responses compared as the memory model returns them.
module tb_sigma_dmem_arb;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 32;
    localparam int MAX_OUTST = 4;

    typedef struct {
        bit          id;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    int          checks = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [31:0] mem_q[$];
    bit          allow_orphan = 1'b0;
    int          outst;

    sigma_dmem_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    sigma_dmem_arb #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk_i   (clk),
        .arst_n_i(arst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Memory-side protocol monitor: a response must always have a read outstanding.
    always @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            outst <= 0;
        end else begin
            assert (!(bus.s_resp_i && outst == 0 && !allow_orphan))
                else $error("FAIL orphan_resp: s_resp_i=1 with outstanding=0 (need >0)");
            outst <= outst + ((bus.s_req_o && bus.s_ack_i && !bus.s_we_o) ? 1 : 0)
                           - ((bus.s_resp_i && outst > 0) ? 1 : 0);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic [65:0] resp_vec(input bit id, input logic [31:0] d);
        return id ? {1'b0, 32'h0, 1'b1, d} : {1'b1, d, 1'b0, 32'h0};
    endfunction

    function automatic logic [65:0] sb_next();
        exp_t e;
        if (sb.size() == 0) return '1;
        e = sb.pop_front();
        return resp_vec(e.id, e.data);
    endfunction

    function automatic logic [65:0] resp_now();
        return {bus.m0_resp_o, bus.m0_rdata_o, bus.m1_resp_o, bus.m1_rdata_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.m0_req_i = 1'b0; bus.m0_we_i = 1'b0; bus.m0_addr_i = '0; bus.m0_be_i = '0; bus.m0_wdata_i = '0;
        bus.m1_req_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_addr_i = '0; bus.m1_be_i = '0; bus.m1_wdata_i = '0;
        bus.s_ack_i = 1'b0; bus.s_resp_i = 1'b0; bus.s_rdata_i = '0;
    endtask

    task automatic mem_drive();
        if (mem_q.size() > 0) begin
            bus.s_resp_i  = 1'b1;
            bus.s_rdata_i = mem_q.pop_front();
        end else begin
            bus.s_resp_i  = 1'b0;
            bus.s_rdata_i = '0;
        end
    endtask

    task automatic issue(input bit id, input logic [31:0] a);
        sb.push_back(exp_t'{id: id, data: rdata_of(a)});
        mem_q.push_back(rdata_of(a));
    endtask

    task automatic test_reset();
        logic [65:0] exp_v;
        arst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #2;
        checks++;
        if ({bus.s_req_o, bus.s_we_o, bus.s_addr_o, bus.s_be_o, bus.s_wdata_o} !== '0) begin
            failures++;
            $display("FAIL reset_s_bus: got req=%b addr=%h, need all 0", bus.s_req_o, bus.s_addr_o);
        end
        checks++;
        if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b00) begin
            failures++;
            $display("FAIL reset_acks: got %b%b, need 00", bus.m0_ack_o, bus.m1_ack_o);
        end
        exp_v = '0;
        checks++;
        if (resp_now() !== exp_v) begin
            failures++;
            $display("FAIL reset_resp: got %h, need %h", resp_now(), exp_v);
        end
        bus.m0_req_i = 1'b1; bus.m1_req_i = 1'b1; bus.s_ack_i = 1'b1;
        bus.s_resp_i = 1'b1; bus.s_rdata_i = 32'h1234_5678;
        #1;
        checks++;
        if ({bus.s_req_o, bus.m0_ack_o, bus.m1_ack_o, bus.m0_resp_o, bus.m1_resp_o} !== 5'b0) begin
            failures++;
            $display("FAIL reset_held_inputs: got s_req=%b acks=%b%b resps=%b%b, need 0", bus.s_req_o,
                     bus.m0_ack_o, bus.m1_ack_o, bus.m0_resp_o, bus.m1_resp_o);
        end
        idle();
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    task automatic test_single();
        logic [65:0] exp_v;
        step();
        bus.m0_req_i = 1'b1; bus.m0_addr_i = 32'h100; bus.m0_be_i = 4'hF; bus.s_ack_i = 1'b1;
        #1;
        checks++;
        if ({bus.m0_ack_o, bus.m1_ack_o, bus.s_req_o, bus.s_addr_o} !== {1'b1, 1'b0, 1'b1, 32'h100}) begin
            failures++;
            $display("FAIL single_ack: got ack=%b%b s_req=%b addr=%h, need 1 0 1 00000100",
                     bus.m0_ack_o, bus.m1_ack_o, bus.s_req_o, bus.s_addr_o);
        end
        sb.push_back(exp_t'{id: 1'b0, data: 32'hDEAD_BEEF});
        step();
        idle();
        bus.s_resp_i = 1'b1; bus.s_rdata_i = 32'hDEAD_BEEF;
        #1;
        exp_v = sb_next();
        checks++;
        if (resp_now() !== exp_v) begin
            failures++;
            $display("FAIL single_resp: got %h, need %h", resp_now(), exp_v);
        end
        step();
        idle();
    endtask

    task automatic test_contention();
        logic [65:0] exp_v;
        logic [31:0] a;
        int n0 = 0;
        int n1 = 0;
        bit g;
        step();
        arst_n = 1'b0;
        #2;
        arst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            bus.m0_req_i = 1'b1; bus.m0_we_i = 1'b0; bus.m0_be_i = 4'hF;
            bus.m1_req_i = 1'b1; bus.m1_we_i = 1'b0; bus.m1_be_i = 4'hF;
            bus.m0_addr_i = 32'h1000 + 32'(4 * n0);
            bus.m1_addr_i = 32'h2000 + 32'(4 * n1);
            bus.s_ack_i = 1'b1;
            mem_drive();
            #1;
            if (bus.s_resp_i) begin
                exp_v = sb_next();
                checks++;
                if (resp_now() !== exp_v) begin
                    failures++;
                    $display("FAIL contention_resp[%0d]: got %h, need %h", i, resp_now(), exp_v);
                end
            end
            g = (i % 2 == 1);
            a = g ? bus.m1_addr_i : bus.m0_addr_i;
            checks++;
            if ({bus.m0_ack_o, bus.m1_ack_o} !== (g ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL contention_grant[%0d]: got acks %b%b, need m%0d", i, bus.m0_ack_o, bus.m1_ack_o, g);
            end
            checks++;
            if (bus.s_addr_o !== a) begin
                failures++;
                $display("FAIL contention_addr[%0d]: got %h, need %h", i, bus.s_addr_o, a);
            end
            issue(g, a);
            if (g) n1++; else n0++;
        end
        step();
        idle();
        mem_drive();
        #1;
        exp_v = sb_next();
        checks++;
        if (resp_now() !== exp_v) begin
            failures++;
            $display("FAIL contention_last_resp: got %h, need %h", resp_now(), exp_v);
        end
        step();
        idle();
    endtask

    task automatic test_lock();
        logic [65:0] exp_v;
        for (int c = 0; c < 4; c++) begin
            step();
            bus.m1_req_i = 1'b1; bus.m1_we_i = 1'b1; bus.m1_addr_i = 32'h200;
            bus.m1_be_i = 4'h3; bus.m1_wdata_i = 32'h1111_2222;
            bus.m0_req_i = (c > 0); bus.m0_we_i = 1'b0; bus.m0_addr_i = 32'h300; bus.m0_be_i = 4'hF;
            bus.s_ack_i = (c == 3);
            #1;
            checks++;
            if ({bus.s_req_o, bus.s_we_o, bus.s_addr_o, bus.s_be_o, bus.s_wdata_o}
                    !== {1'b1, 1'b1, 32'h200, 4'h3, 32'h1111_2222}) begin
                failures++;
                $display("FAIL lock_fields[%0d]: got we=%b addr=%h wdata=%h, need 1 00000200 11112222",
                         c, bus.s_we_o, bus.s_addr_o, bus.s_wdata_o);
            end
            checks++;
            if ({bus.m0_ack_o, bus.m1_ack_o} !== ((c == 3) ? 2'b01 : 2'b00)) begin
                failures++;
                $display("FAIL lock_ack[%0d]: got %b%b", c, bus.m0_ack_o, bus.m1_ack_o);
            end
        end
        step();
        bus.m1_req_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_addr_i = '0; bus.m1_be_i = '0; bus.m1_wdata_i = '0;
        #1;
        checks++;
        if ({bus.m0_ack_o, bus.m1_ack_o, bus.s_we_o, bus.s_addr_o} !== {1'b1, 1'b0, 1'b0, 32'h300}) begin
            failures++;
            $display("FAIL lock_release: got acks=%b%b addr=%h, need 10 00000300", bus.m0_ack_o, bus.m1_ack_o, bus.s_addr_o);
        end
        issue(1'b0, 32'h300);
        step();
        idle();
        mem_drive();
        #1;
        exp_v = sb_next();
        checks++;
        if (resp_now() !== exp_v) begin
            failures++;
            $display("FAIL lock_resp: got %h, need %h", resp_now(), exp_v);
        end
        step();
        idle();
    endtask

    task automatic test_fifo_full();
        logic [65:0] exp_v;
        for (int n = 0; n < MAX_OUTST; n++) begin
            step();
            idle();
            bus.m0_req_i = 1'b1; bus.m0_addr_i = 32'h400 + 32'(4 * n); bus.m0_be_i = 4'hF; bus.s_ack_i = 1'b1;
            #1;
            checks++;
            if (bus.m0_ack_o !== 1'b1) begin
                failures++;
                $display("FAIL full_fill[%0d]: got m0_ack=%b, need 1", n, bus.m0_ack_o);
            end
            issue(1'b0, bus.m0_addr_i);
        end
        step();
        bus.m0_addr_i = 32'h410;
        bus.m1_req_i = 1'b1; bus.m1_we_i = 1'b1; bus.m1_addr_i = 32'h500; bus.m1_be_i = 4'hF; bus.m1_wdata_i = 32'hCAFE_0001;
        #1;
        checks++;
        if ({bus.m0_ack_o, bus.m1_ack_o, bus.s_we_o, bus.s_addr_o} !== {1'b0, 1'b1, 1'b1, 32'h500}) begin
            failures++;
            $display("FAIL full_write_passes: got acks=%b%b we=%b addr=%h, need 01 1 00000500",
                     bus.m0_ack_o, bus.m1_ack_o, bus.s_we_o, bus.s_addr_o);
        end
        step();
        bus.m1_req_i = 1'b0; bus.m1_we_i = 1'b0; bus.m1_addr_i = '0; bus.m1_be_i = '0; bus.m1_wdata_i = '0;
        #1;
        checks++;
        if ({bus.s_req_o, bus.m0_ack_o} !== 2'b00) begin
            failures++;
            $display("FAIL full_read_blocked: got s_req=%b m0_ack=%b, need 00", bus.s_req_o, bus.m0_ack_o);
        end
        step();
        mem_drive();
        #1;
        exp_v = sb_next();
        checks++;
        if (resp_now() !== exp_v) begin
            failures++;
            $display("FAIL full_resp: got %h, need %h", resp_now(), exp_v);
        end
        checks++;
        if ({bus.s_req_o, bus.m0_ack_o} !== 2'b00) begin
            failures++;
            $display("FAIL full_same_cycle_pop: got s_req=%b m0_ack=%b, need 00", bus.s_req_o, bus.m0_ack_o);
        end
        step();
        bus.s_resp_i = 1'b0; bus.s_rdata_i = '0;
        #1;
        checks++;
        if ({bus.m0_ack_o, bus.s_addr_o} !== {1'b1, 32'h410}) begin
            failures++;
            $display("FAIL full_unblocked: got m0_ack=%b addr=%h, need 1 00000410", bus.m0_ack_o, bus.s_addr_o);
        end
        issue(1'b0, 32'h410);
    endtask

    task automatic test_push_pop();
        logic [65:0] exp_v;
        bit id;
        step();
        idle();
        mem_drive();
        #1;
        exp_v = sb_next();
        checks++;
        if (resp_now() !== exp_v) begin
            failures++;
            $display("FAIL pp_first_resp: got %h, need %h", resp_now(), exp_v);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            idle();
            id = (k % 2 == 0);
            if (id) begin
                bus.m1_req_i = 1'b1; bus.m1_addr_i = 32'h600 + 32'(4 * k); bus.m1_be_i = 4'hF;
            end else begin
                bus.m0_req_i = 1'b1; bus.m0_addr_i = 32'h700 + 32'(4 * k); bus.m0_be_i = 4'hF;
            end
            bus.s_ack_i = 1'b1;
            mem_drive();
            #1;
            exp_v = sb_next();
            checks++;
            if (resp_now() !== exp_v) begin
                failures++;
                $display("FAIL pp_resp[%0d]: got %h, need %h", k, resp_now(), exp_v);
            end
            checks++;
            if ({bus.m0_ack_o, bus.m1_ack_o} !== (id ? 2'b01 : 2'b10)) begin
                failures++;
                $display("FAIL pp_ack[%0d]: got %b%b, need m%0d", k, bus.m0_ack_o, bus.m1_ack_o, id);
            end
            issue(id, id ? bus.m1_addr_i : bus.m0_addr_i);
        end
        // Occupancy must still be MAX_OUTST-1, so exactly one more read fits.
        step();
        idle();
        bus.m0_req_i = 1'b1; bus.m0_addr_i = 32'h800; bus.m0_be_i = 4'hF; bus.s_ack_i = 1'b1;
        #1;
        checks++;
        if (bus.m0_ack_o !== 1'b1) begin
            failures++;
            $display("FAIL pp_count_kept: got m0_ack=%b, need 1", bus.m0_ack_o);
        end
        issue(1'b0, 32'h800);
        for (int k = 0; k < 2 * MAX_OUTST && mem_q.size() > 0; k++) begin
            step();
            idle();
            mem_drive();
            #1;
            exp_v = sb_next();
            checks++;
            if (resp_now() !== exp_v) begin
                failures++;
                $display("FAIL pp_drain[%0d]: got %h, need %h", k, resp_now(), exp_v);
            end
        end
        step();
        idle();
    endtask

    task automatic test_reset_mid();
        logic [65:0] exp_v;
        for (int n = 0; n < 2; n++) begin
            step();
            idle();
            bus.m0_req_i = 1'b1; bus.m0_addr_i = 32'h900 + 32'(4 * n); bus.m0_be_i = 4'hF; bus.s_ack_i = 1'b1;
            #1;
            checks++;
            if (bus.m0_ack_o !== 1'b1) begin
                failures++;
                $display("FAIL rst_pre_read[%0d]: got m0_ack=%b, need 1", n, bus.m0_ack_o);
            end
        end
        step();
        idle();
        bus.m1_req_i = 1'b1; bus.m1_we_i = 1'b1; bus.m1_addr_i = 32'hA00; bus.m1_be_i = 4'hF; bus.m1_wdata_i = 32'h5555_AAAA;
        step();
        bus.m0_req_i = 1'b1; bus.m0_addr_i = 32'hB00; bus.m0_be_i = 4'hF;
        #1;
        checks++;
        if ({bus.s_req_o, bus.s_addr_o} !== {1'b1, 32'hA00}) begin
            failures++;
            $display("FAIL rst_locked: got s_req=%b addr=%h, need 1 00000A00", bus.s_req_o, bus.s_addr_o);
        end
        arst_n = 1'b0;
        #1;
        checks++;
        if ({bus.s_req_o, bus.s_we_o, bus.s_addr_o, bus.s_be_o, bus.s_wdata_o,
             bus.m0_ack_o, bus.m1_ack_o} !== '0) begin
            failures++;
            $display("FAIL rst_outputs: got s_req=%b addr=%h, need all 0", bus.s_req_o, bus.s_addr_o);
        end
        bus.s_ack_i = 1'b1; bus.s_resp_i = 1'b1; bus.s_rdata_i = 32'h0BAD_0BAD;
        #1;
        exp_v = '0;
        checks++;
        if ({bus.s_req_o, bus.m0_ack_o, bus.m1_ack_o} !== 3'b000 || resp_now() !== exp_v) begin
            failures++;
            $display("FAIL rst_in_reset_resp: got s_req=%b resp=%h, need all 0", bus.s_req_o, resp_now());
        end
        idle();
        sb.delete();
        mem_q.delete();
        @(negedge clk);
        arst_n = 1'b1;
        step();
        allow_orphan = 1'b1;
        bus.s_resp_i = 1'b1; bus.s_rdata_i = 32'hBAD0_BAD0;
        #1;
        checks++;
        if (resp_now() !== exp_v) begin
            failures++;
            $display("FAIL rst_stale_resp: got %h, need %h", resp_now(), exp_v);
        end
        step();
        allow_orphan = 1'b0;
        idle();
        bus.m0_req_i = 1'b1; bus.m0_addr_i = 32'hB00; bus.m0_be_i = 4'hF;
        bus.m1_req_i = 1'b1; bus.m1_addr_i = 32'hC00; bus.m1_be_i = 4'hF;
        bus.s_ack_i = 1'b1;
        #1;
        checks++;
        if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b10) begin
            failures++;
            $display("FAIL rst_first_winner: got acks %b%b, need 10", bus.m0_ack_o, bus.m1_ack_o);
        end
        issue(1'b0, 32'hB00);
        step();
        bus.m0_addr_i = 32'hB04;
        #1;
        checks++;
        if ({bus.m0_ack_o, bus.m1_ack_o} !== 2'b01) begin
            failures++;
            $display("FAIL rst_second_winner: got acks %b%b, need 01", bus.m0_ack_o, bus.m1_ack_o);
        end
        issue(1'b1, 32'hC00);
        for (int k = 0; k < 2; k++) begin
            step();
            idle();
            mem_drive();
            #1;
            exp_v = sb_next();
            checks++;
            if (resp_now() !== exp_v) begin
                failures++;
                $display("FAIL rst_post_resp[%0d]: got %h, need %h", k, resp_now(), exp_v);
            end
        end
        step();
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single();
        test_contention();
        test_lock();
        test_fifo_full();
        test_push_pop();
        test_reset_mid();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
